// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle of the buffered UART transmitter: push port, FIFO status
// and the serial line with its frame status flags.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              i_Wr_En;
    logic [7:0]        i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_TX_Serial;
    logic              o_TX_Active;
    logic              o_TX_Done;

    modport master (
        output i_Wr_En,
        output i_Wr_Byte,
        input  o_Full,
        input  o_Empty,
        input  o_Count,
        input  o_Overflow,
        input  o_TX_Serial,
        input  o_TX_Active,
        input  o_TX_Done
    );

    modport slave (
        input  i_Wr_En,
        input  i_Wr_Byte,
        output o_Full,
        output o_Empty,
        output o_Count,
        output o_Overflow,
        output o_TX_Serial,
        output o_TX_Active,
        output o_TX_Done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes pushed by the host are queued in a
// small FIFO and sent LSB first, back-to-back while the FIFO holds data.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line high, waiting for the FIFO to become non-empty
// START | start bit (line low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, shift[bit_idx], CLKS_PER_BIT cycles each
// STOP  | stop bit (line high); last cycle pops the next byte if any
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic            i_Clock,
    input  logic            i_Rst_n,
    uart_tx_fifo_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   clk_cnt;
    logic [CNT_W-1:0]   clk_cnt_next;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_next;
    logic [7:0]         shift;
    logic [7:0]         shift_next;
    logic               serial;
    logic               serial_next;
    logic               pop;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count;
    logic               overflow;
    logic               full;
    logic               empty;
    logic               push;
    logic               bit_last;

    // Status flags come straight from the registered occupancy, so a push
    // and a pop in the same cycle never make them glitch.
    assign full     = (count == COUNT_FULL);
    assign empty    = (count == '0);
    assign push     = bus.i_Wr_En && !full;
    assign bit_last = (clk_cnt == CNT_LAST);

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_Wr_Byte;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse. A push seen while full
    // is dropped even if the transmitter pops in that same cycle.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            overflow <= bus.i_Wr_En && full;
        end
    end

    // Transmitter state, counters, shift register and the registered line.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            serial  <= 1'b1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            serial  <= serial_next;
        end
    end

    // Next-state logic. The line value for the coming cycle is decoded from
    // the next state so the start bit appears in the cycle right after a pop.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;
        serial_next  = 1'b1;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr];
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_last) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_last) begin
                    clk_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_last) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[bit_idx_next];
            default: serial_next = 1'b1;
        endcase
    end

    assign bus.o_Full      = full;
    assign bus.o_Empty     = empty;
    assign bus.o_Count     = count;
    assign bus.o_Overflow  = overflow;
    assign bus.o_TX_Serial = serial;
    assign bus.o_TX_Active = (state != IDLE);
    assign bus.o_TX_Done   = (state == STOP) && bit_last;

endmodule
